// File: rtl/lite_to_stream_serializer_pkg.sv
// Shared widths, payload-mask encodings and derived-size helpers
// for the lite-to-stream serializer.
package lite_to_stream_serializer_pkg;

    localparam int MSG_TYPE_W    = 4;
    localparam int SIZE_W        = 3;
    localparam int NUM_MSG_TYPES = 1 << MSG_TYPE_W;

    localparam logic [NUM_MSG_TYPES-1:0] PAYLOAD_NONE  = '0;
    localparam logic [NUM_MSG_TYPES-1:0] PAYLOAD_TYPE1 = 16'h0002;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    function automatic int words_f(int in_w, int out_w);
        return in_w / out_w;
    endfunction

    function automatic int off_f(int out_w);
        return $clog2(out_w / 8);
    endfunction

    function automatic int idx_f(int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Beats per message: 2^size bytes split into beats, at least one,
    // never more than the words held by one block.
    function automatic int beats_f(logic has_data,
                                   logic [SIZE_W-1:0] size,
                                   int off,
                                   int words);
        int beats;
        beats = 1;
        if (has_data && (int'(size) > off)) begin
            beats = 1 << (int'(size) - off);
        end
        if (beats > words) begin
            beats = words;
        end
        return beats;
    endfunction

endpackage

// File: rtl/lite_to_stream_serializer_if.sv
// Wide lite message channel in, narrow beat stream out.
// Signal names are from the serializer's point of view.
interface lite_to_stream_serializer_if #(
    parameter int paddr_width_p    = 40,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter int meta_width_p     = 32
);
    import lite_to_stream_serializer_pkg::*;

    logic [paddr_width_p-1:0]    in_addr_i;
    logic [SIZE_W-1:0]           in_size_i;
    logic [MSG_TYPE_W-1:0]       in_msg_type_i;
    logic [meta_width_p-1:0]     in_meta_i;
    logic [in_data_width_p-1:0]  in_data_i;
    logic                        in_v_i;
    logic                        in_ready_o;

    logic [paddr_width_p-1:0]    out_addr_o;
    logic [SIZE_W-1:0]           out_size_o;
    logic [MSG_TYPE_W-1:0]       out_msg_type_o;
    logic [meta_width_p-1:0]     out_meta_o;
    logic [out_data_width_p-1:0] out_data_o;
    logic                        out_v_o;
    logic                        out_ready_i;
    logic                        out_lock_o;

    modport slave (
        input  in_addr_i, in_size_i, in_msg_type_i,
        input  in_meta_i, in_data_i, in_v_i,
        output in_ready_o,
        output out_addr_o, out_size_o, out_msg_type_o,
        output out_meta_o, out_data_o, out_v_o, out_lock_o,
        input  out_ready_i
    );

    modport master (
        output in_addr_i, in_size_i, in_msg_type_i,
        output in_meta_i, in_data_i, in_v_i,
        input  in_ready_o,
        input  out_addr_o, out_size_o, out_msg_type_o,
        input  out_meta_o, out_data_o, out_v_o, out_lock_o,
        output out_ready_i
    );

endinterface

// File: rtl/lite_to_stream_serializer_stream_beat_counter.sv
// Beat index within the current message: cleared on accept,
// advances per handshake, saturating at the message's last beat.
module stream_beat_counter #(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    input  logic [width_p-1:0] last_idx_i,
    output logic [width_p-1:0] cnt_o,
    output logic               last_o
);

    logic [width_p-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == last_idx_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (up_i && !last_o) begin
            cnt_d = cnt_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lite_to_stream_serializer.sv
// One-entry buffer that replays a wide lite message as a locked
// burst of narrow beats with in-block wrapping beat addresses.
module lite_to_stream_serializer
    import lite_to_stream_serializer_pkg::*;
#(
    parameter int paddr_width_p    = 40,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter int meta_width_p     = 32,
    parameter logic [NUM_MSG_TYPES-1:0] payload_mask_p = PAYLOAD_NONE
) (
    input logic clk_i,
    input logic reset_i,
    lite_to_stream_serializer_if.slave bus
);

    localparam int W   = words_f(in_data_width_p, out_data_width_p);
    localparam int OFF = off_f(out_data_width_p);
    localparam int IDX = idx_f(W);

    buf_state_e state_q, state_d;

    logic [paddr_width_p-1:0]    addr_q;
    logic [SIZE_W-1:0]           size_q;
    logic [MSG_TYPE_W-1:0]       type_q;
    logic [meta_width_p-1:0]     meta_q;
    logic [in_data_width_p-1:0]  data_q;
    logic [IDX-1:0]              last_idx_q, last_idx_d;

    logic                        in_ready;
    logic                        accept;
    logic                        out_v;
    logic                        beat_fire;
    logic                        last;
    logic [IDX-1:0]              beat_q;
    logic [paddr_width_p-1:0]    beat_addr;
    logic [out_data_width_p-1:0] beat_data;

    // Reset gates ready so nothing is taken while the buffer is cleared.
    assign in_ready  = (state_q == ST_EMPTY) & ~reset_i;
    assign accept    = bus.in_v_i & in_ready;
    assign out_v     = (state_q == ST_FULL);
    assign beat_fire = out_v & bus.out_ready_i;

    assign last_idx_d = IDX'(beats_f(payload_mask_p[bus.in_msg_type_i],
                                     bus.in_size_i, OFF, W) - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (beat_fire && last) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q     <= bus.in_addr_i;
            size_q     <= bus.in_size_i;
            type_q     <= bus.in_msg_type_i;
            meta_q     <= bus.in_meta_i;
            data_q     <= bus.in_data_i;
            last_idx_q <= last_idx_d;
        end
    end

    stream_beat_counter #(
        .width_p (IDX)
    ) u_beat_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (accept),
        .up_i       (beat_fire),
        .last_idx_i (last_idx_q),
        .cnt_o      (beat_q),
        .last_o     (last)
    );

    generate
        if (W == 1) begin : g_single
            assign beat_data = data_q[out_data_width_p-1:0];
            assign beat_addr = addr_q;
        end else begin : g_multi
            logic [W-1:0][out_data_width_p-1:0] words;
            logic [IDX:0] field_sum;
            logic [IDX:0] field_wrap;

            assign words      = data_q;
            assign beat_data  = words[beat_q];
            assign field_sum  = {1'b0, addr_q[OFF +: IDX]}
                              + {1'b0, beat_q};
            // Beat address wraps inside the block, never crossing it.
            assign field_wrap = field_sum % (IDX+1)'(W);

            always_comb begin
                beat_addr = addr_q;
                beat_addr[OFF +: IDX] = field_wrap[IDX-1:0];
            end
        end
    endgenerate

    assign bus.in_ready_o     = in_ready;
    assign bus.out_v_o        = out_v;
    assign bus.out_lock_o     = out_v & ~last;
    assign bus.out_addr_o     = beat_addr;
    assign bus.out_data_o     = beat_data;
    assign bus.out_size_o     = size_q;
    assign bus.out_msg_type_o = type_q;
    assign bus.out_meta_o     = meta_q;

endmodule

// File: tb/tb_lite_to_stream_serializer.sv
// Scoreboard bench: a driver queues expected beats from a reference
// model, a negedge monitor compares every presented beat.
module tb_lite_to_stream_serializer;
    import lite_to_stream_serializer_pkg::*;

    localparam int AW = 40;
    localparam int IW = 512;
    localparam int OW = 64;
    localparam int MW = 32;
    localparam int W  = IW / OW;
    localparam logic [15:0] MASK = PAYLOAD_TYPE1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [3:0]    mtype;
        logic [MW-1:0] meta;
        logic [OW-1:0] data;
        logic          lock;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset;
    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];
    bit    mon_en = 1'b0;
    int    rdy_mode = 0;

    lite_to_stream_serializer_if #(
        .paddr_width_p    (AW),
        .in_data_width_p  (IW),
        .out_data_width_p (OW),
        .meta_width_p     (MW)
    ) bus ();

    lite_to_stream_serializer #(
        .paddr_width_p    (AW),
        .in_data_width_p  (IW),
        .out_data_width_p (OW),
        .meta_width_p     (MW),
        .payload_mask_p   (MASK)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: beat count from byte size, address word field
    // advanced modulo the block, data sliced word by word.
    function automatic void push_msg(input logic [AW-1:0] a,
                                     input logic [2:0] s,
                                     input logic [3:0] t,
                                     input logic [MW-1:0] m,
                                     input logic [IW-1:0] d);
        logic [15:0] mask_v;
        int n;
        int field;
        beat_t b;
        mask_v = MASK;
        n = 1;
        if (mask_v[t]) begin
            n = (1 << s) / (OW / 8);
            if (n < 1) n = 1;
            if (n > W) n = W;
        end
        field = int'((a >> 3) & 40'd7);
        for (int k = 0; k < n; k++) begin
            b.addr  = (a & ~(AW'(7) << 3))
                    | (AW'((field + k) % W) << 3);
            b.size  = s;
            b.mtype = t;
            b.meta  = m;
            b.data  = d[k*OW +: OW];
            b.lock  = (k != n - 1);
            sb.push_back(b);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready_i = 1'b1;
            1:       bus.out_ready_i = (bus.out_ready_i !== 1'b1);
            default: bus.out_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("out_v", bus.out_v_o, sb.size() != 0);
            chk("in_ready", bus.in_ready_o, sb.size() == 0);
            if (bus.out_v_o && sb.size() != 0) begin
                chk("addr", bus.out_addr_o, sb[0].addr);
                chk("data", bus.out_data_o, sb[0].data);
                chk("lock", bus.out_lock_o, sb[0].lock);
                chk("size", bus.out_size_o, sb[0].size);
                chk("type", bus.out_msg_type_o, sb[0].mtype);
                chk("meta", bus.out_meta_o, sb[0].meta);
                if (bus.out_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [AW-1:0] a,
                        input logic [2:0] s,
                        input logic [3:0] t,
                        input logic [MW-1:0] m,
                        input logic [IW-1:0] d);
        int waited;
        waited = 0;
        bus.in_addr_i     = a;
        bus.in_size_i     = s;
        bus.in_msg_type_i = t;
        bus.in_meta_i     = m;
        bus.in_data_i     = d;
        bus.in_v_i        = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready 0 want 1");
            bus.in_v_i = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        push_msg(a, s, t, m, d);
        bus.in_v_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats left want 0",
                     sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] seq_data;
    logic [IW-1:0] rnd_data;

    initial begin
        for (int i = 0; i < W; i++) seq_data[i*OW +: OW] = OW'(i);
        reset             = 1'b1;
        bus.in_v_i        = 1'b0;
        bus.in_addr_i     = '0;
        bus.in_size_i     = '0;
        bus.in_msg_type_i = '0;
        bus.in_meta_i     = '0;
        bus.in_data_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_v", bus.out_v_o, 1'b0);
        chk("rst_lock", bus.out_lock_o, 1'b0);
        chk("rst_in_ready", bus.in_ready_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        send(40'h00_1000_0028, 3'd6, 4'd1, 32'hA5A5_0001, seq_data);
        drain();
        send(40'h40, 3'd6, 4'd0, 32'h0000_0002, seq_data);
        drain();
        send(40'h18, 3'd3, 4'd1, 32'h0000_0003, seq_data);
        send(40'h30, 3'd5, 4'd1, 32'h0000_0004, seq_data);
        drain();
        send(40'h77_0000_00F8, 3'd7, 4'd1, 32'h0000_0005, seq_data);
        send(40'h05, 3'd0, 4'd1, 32'h0000_0006, seq_data);
        drain();

        rdy_mode = 1;
        send(40'h00_1000_0028, 3'd6, 4'd1, 32'hA5A5_0007, seq_data);
        drain();
        rdy_mode = 2;
        send(40'h00_2000_0010, 3'd6, 4'd1, 32'h0000_0008, seq_data);
        send(40'h00_3000_0008, 3'd4, 4'd1, 32'h0000_0009, ~seq_data);
        drain();

        rdy_mode = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        send(40'h00_1000_0028, 3'd6, 4'd1, 32'h0000_000A, seq_data);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready_o, 1'b0);
        @(negedge clk);
        chk("midrst_out_v", bus.out_v_o, 1'b0);
        chk("midrst_lock", bus.out_lock_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", bus.in_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_beats", bus.out_v_o, 1'b0);
        end
        @(posedge clk);
        #1;
        sb.delete();
        mon_en = 1'b1;

        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < IW / 32; i++) begin
                rnd_data[i*32 +: 32] = $urandom();
            end
            send({8'($urandom()), 32'($urandom())},
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 3)),
                 32'($urandom()),
                 rnd_data);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
